rro_pipe: RTL
=============

Name: rro_pipe

Overview:
- Pipelined, parametrised range-reduction operator (RRO) for the SFU front end.
- Converts an IEEE754 binary32 operand into the fixed-point or split form consumed by the piecewise-polynomial evaluator.
- Supports two modes: exp2 argument reduction and log2 exponent/mantissa split.
- Two-stage pipeline with valid/ready handshake and a sideband tag, sitting between the SFU operand issue logic and the coefficient-lookup stage.

Parameters:
- INT_W, 8, integer bits of the exp2 fixed-point result, including the sign bit; legal range 8..16.
- TAG_W, 4, width of the opaque tag carried alongside each operation.
- OUT_W, INT_W+24, derived result width (localparam): 1 flag bit plus INT_W+23 payload bits.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand valid
- in_ready  out  1  operand accepted when in_valid && in_ready
- in_data  in  32  binary32 operand
- in_mode  in  1  0 = exp2, 1 = log2
- in_tag  in  TAG_W  sideband tag
- out_valid  out  1  result valid
- out_ready  in  1  downstream accept
- out_result  out  OUT_W  bit OUT_W-1 = special flag; bits OUT_W-2:0 = payload or special code
- out_mode  out  1  mode echoed with the result
- out_tag  out  TAG_W  tag echoed with the result

Behaviour:
- Reset: both stage valid bits clear, so out_valid=0. out_result, out_mode and out_tag reset to 0. in_ready=1 as soon as rst_n is released. Asserting reset mid-operation drops all in-flight operations; nothing is replayed.
- Latency is exactly 2 cycles from an accepted input to out_valid when the pipe is not stalled. Throughput is 1 operation per cycle.
- Handshake:
  - Each stage advances when it is empty or its successor is accepting: ready_s = !valid_s || ready_(s+1).
  - in_ready = ready_1 (combinational from out_ready through the stage valids; no skid buffer).
  - out_result, out_mode and out_tag hold stable while out_valid && !out_ready.
  - A simultaneous accept and retire on a full pipe moves every stage forward in the same cycle.
- Let E = in_data[30:23], M = in_data[22:0], S = in_data[31], and TH = 127+INT_W-2.
- Special-code layout: out_result[OUT_W-1]=1 and code = out_result[OUT_W-2:OUT_W-9]. For a NaN code, the low 23 bits carry M; all other lower bits are 0.
- Special codes: CODE_POSINF=8'h0F, CODE_ZERO=8'hF0, CODE_ONE=8'h00, CODE_NAN=8'hFF, CODE_NEGINF=8'h3C.
- exp2 mode, in priority order:
  - +Inf -> CODE_POSINF.
  - -Inf -> CODE_ZERO.
  - NaN -> CODE_NAN.
  - E>TH && !S -> CODE_POSINF.
  - E>TH && S -> CODE_ZERO.
  - E==0 (zero or subnormal) -> CODE_ONE.
  - Otherwise: fixed = {001, M, zeros} (INT_W+24 bits) >> (TH-E). Shift amounts >= OUT_W give 0. If S, apply two's-complement negation. Payload = low OUT_W-1 bits; flag = 0.
- log2 mode, in priority order:
  - NaN or S=1 with a nonzero value -> CODE_NAN. A negative-number NaN has zero payload.
  - ±0 or subnormal -> CODE_NEGINF.
  - +Inf -> CODE_POSINF.
  - Otherwise: flag = 0; payload = {sign-extended (E-127) in INT_W bits, M}.
- Stage split:
  - Stage 1 registers the classification, the shifted magnitude (exp2) or unbiased exponent (log2), S, mode and tag.
  - Stage 2 registers the negation, the special/normal mux and the output fields.

Decomposition:
- Package rro_pkg holds:
  - the special-code constants;
  - the binary32 field-extraction constants (bias 127, field widths);
  - a classification enum: NORMAL, ZERO_SUB, POS_INF, NEG_INF, NAN.
- One natural sub-module, rro_classify: combinational binary32 classifier producing the enum, shared with other SFU front ends.
- Pipeline registers and handshake stay in rro_pipe.

Test Plan:
- exp2, in_data=0x3F800000 (1.0), out_ready=1 -> after 2 cycles out_result=0x00800000.
- exp2 0xBF800000 (-1.0) -> 0x7F800000. exp2 0x43000000 (128.0) -> 0x87800000. exp2 0xC3000000 -> 0xF8000000. exp2 0x00000001 -> 0x80000000. exp2 0x7FC00001 -> 0xFFC00001.
- log2 0x41000000 (8.0) -> 0x01800000. log2 0x3F000000 (0.5) -> 0x7F800000. log2 0xC0000000 -> 0xFF800000. log2 0x00000000 -> 0x9E000000.
- Back-to-back 10 ops with tags 0..9, with out_ready held low for cycles 3–6 -> in_ready drops once both stages are full; results emerge in order with matching tags, none lost or duplicated, and out_result is stable during the stall.
- Assert rst_n low with both stages valid -> out_valid falls immediately. After release, the first new operation appears exactly 2 cycles after acceptance.
- INT_W=12 build, exp2 0x45000000 (2048.0) -> CODE_POSINF; exp2 0x44800000 (1024.0) -> payload 1024<<23, flag 0.

Source files
------------

// File: rtl/rro_pkg.sv
// Shared constants and types for the SFU range-reduction operator.
// Holds binary32 field geometry, special result codes and the operand class enum.
package rro_pkg;

  localparam int F32_BIAS  = 127;
  localparam int F32_EXP_W = 8;
  localparam int F32_MAN_W = 23;

  localparam logic [7:0] CODE_POSINF = 8'h0F;
  localparam logic [7:0] CODE_ZERO   = 8'hF0;
  localparam logic [7:0] CODE_ONE    = 8'h00;
  localparam logic [7:0] CODE_NAN    = 8'hFF;
  localparam logic [7:0] CODE_NEGINF = 8'h3C;

  typedef enum logic [2:0] {
    NORMAL   = 3'd0,
    ZERO_SUB = 3'd1,
    POS_INF  = 3'd2,
    NEG_INF  = 3'd3,
    NAN      = 3'd4
  } rro_cls_e;

endpackage

// File: rtl/rro_classify.sv
// Combinational binary32 classifier shared by the SFU front ends.
// Zero and subnormal share one class; infinities are split by sign.
module rro_classify
  import rro_pkg::*;
(
  input  logic [31:0] i_data,
  output rro_cls_e    o_cls
);

  logic [F32_EXP_W-1:0] w_exp;
  logic [F32_MAN_W-1:0] w_man;
  logic                 w_sgn;

  assign w_exp = i_data[F32_MAN_W +: F32_EXP_W];
  assign w_man = i_data[F32_MAN_W-1:0];
  assign w_sgn = i_data[31];

  always_comb begin
    o_cls = NORMAL;
    if (w_exp == '0)
      o_cls = ZERO_SUB;
    else if (w_exp == '1)
      o_cls = (w_man != '0) ? NAN : (w_sgn ? NEG_INF : POS_INF);
  end

endmodule

// File: rtl/rro_pipe.sv
// Two-stage range-reduction operator: exp2 fixed-point reduction or log2 split.
// Stage 1 classifies and shifts, stage 2 negates and muxes specials.
module rro_pipe
  import rro_pkg::*;
#(
  parameter  int INT_W = 8,
  parameter  int TAG_W = 4,
  localparam int OUT_W = INT_W + 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_result,
  output logic             out_mode,
  output logic [TAG_W-1:0] out_tag
);

  localparam int TH    = F32_BIAS + INT_W - 2;
  localparam int PAY_W = OUT_W - 1;
  localparam int LOW_W = OUT_W - 9;

  logic [2:1] r_vld_pipe;
  logic       w_rdy1, w_rdy2;

  assign w_rdy2   = !r_vld_pipe[2] || out_ready;
  assign w_rdy1   = !r_vld_pipe[1] || w_rdy2;
  assign in_ready = w_rdy1;

  logic [F32_EXP_W-1:0] w_exp;
  logic [F32_MAN_W-1:0] w_man;
  logic                 w_sgn;
  rro_cls_e             w_cls;
  logic                 w_ovf;
  logic [8:0]           w_sh;
  logic [INT_W-1:0]     w_unb;
  logic [PAY_W-1:0]     w_fix, w_shifted, w_lpay;

  assign w_exp = in_data[F32_MAN_W +: F32_EXP_W];
  assign w_man = in_data[F32_MAN_W-1:0];
  assign w_sgn = in_data[31];

  rro_classify u_cls (
    .i_data (in_data),
    .o_cls  (w_cls)
  );

  // Fixed point with 23 fraction bits; leading one sits at weight 2^(INT_W-2) before shifting.
  assign w_ovf     = {1'b0, w_exp} > 9'(TH);
  assign w_sh      = 9'(TH) - {1'b0, w_exp};
  assign w_fix     = {2'b01, w_man, {(INT_W-2){1'b0}}};
  assign w_shifted = (w_sh >= 9'(OUT_W)) ? '0 : (w_fix >> w_sh);
  assign w_unb     = INT_W'({1'b0, w_exp}) - INT_W'(F32_BIAS);
  assign w_lpay    = {w_unb, w_man};

  rro_cls_e             r1_cls;
  logic                 r1_sgn, r1_ovf, r1_mode;
  logic [TAG_W-1:0]     r1_tag;
  logic [F32_MAN_W-1:0] r1_man;
  logic [PAY_W-1:0]     r1_mag;

  logic [OUT_W-1:0]     r2_res;
  logic                 r2_mode;
  logic [TAG_W-1:0]     r2_tag;

  logic [PAY_W-1:0]     w_neg, w_pay;
  logic                 w_spec;
  logic [7:0]           w_code;
  logic [F32_MAN_W-1:0] w_nan_man;
  logic [OUT_W-1:0]     w_res;

  assign w_neg = -r1_mag;

  always_comb begin
    w_spec    = 1'b0;
    w_code    = CODE_ONE;
    w_nan_man = '0;
    w_pay     = r1_mag;
    if (!r1_mode) begin
      case (r1_cls)
        POS_INF:  begin w_spec = 1'b1; w_code = CODE_POSINF; end
        NEG_INF:  begin w_spec = 1'b1; w_code = CODE_ZERO;   end
        NAN:      begin w_spec = 1'b1; w_code = CODE_NAN; w_nan_man = r1_man; end
        ZERO_SUB: begin w_spec = 1'b1; w_code = CODE_ONE;    end
        default: begin
          if (r1_ovf) begin
            w_spec = 1'b1;
            w_code = r1_sgn ? CODE_ZERO : CODE_POSINF;
          end else if (r1_sgn) begin
            w_pay = w_neg;
          end
        end
      endcase
    end else begin
      if (r1_cls == NAN) begin
        w_spec = 1'b1; w_code = CODE_NAN; w_nan_man = r1_man;
      end else if (r1_sgn && (r1_cls != ZERO_SUB || r1_man != '0)) begin
        // Negative operands yield a NaN code with an empty payload.
        w_spec = 1'b1; w_code = CODE_NAN;
      end else if (r1_cls == ZERO_SUB) begin
        w_spec = 1'b1; w_code = CODE_NEGINF;
      end else if (r1_cls == POS_INF) begin
        w_spec = 1'b1; w_code = CODE_POSINF;
      end
    end
  end

  assign w_res = w_spec ? {1'b1, w_code, LOW_W'(w_nan_man)} : {1'b0, w_pay};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
      r1_cls     <= NORMAL;
      r1_sgn     <= 1'b0;
      r1_ovf     <= 1'b0;
      r1_mode    <= 1'b0;
      r1_tag     <= '0;
      r1_man     <= '0;
      r1_mag     <= '0;
      r2_res     <= '0;
      r2_mode    <= 1'b0;
      r2_tag     <= '0;
    end else begin
      if (w_rdy1) r_vld_pipe[1] <= in_valid;
      if (w_rdy2) r_vld_pipe[2] <= r_vld_pipe[1];
      if (w_rdy1 && in_valid) begin
        r1_cls  <= w_cls;
        r1_sgn  <= w_sgn;
        r1_ovf  <= w_ovf;
        r1_mode <= in_mode;
        r1_tag  <= in_tag;
        r1_man  <= w_man;
        r1_mag  <= in_mode ? w_lpay : w_shifted;
      end
      if (w_rdy2 && r_vld_pipe[1]) begin
        r2_res  <= w_res;
        r2_mode <= r1_mode;
        r2_tag  <= r1_tag;
      end
    end
  end

  assign out_valid  = r_vld_pipe[2];
  assign out_result = r2_res;
  assign out_mode   = r2_mode;
  assign out_tag    = r2_tag;

endmodule
